serial_adder: RTL and testbench

- Bit-serial N-bit adder. It consumes two WIDTH-bit operands through a valid/ready handshake.
- It adds one bit per clock, LSB first, using a carry flop. The per-bit sum/carry is the same decoded sum/carry function as the team's half adder stage, extended with carry-in.
- It returns the WIDTH-bit sum plus carry-out through a second valid/ready handshake.
- It sits downstream of operand producers and upstream of any result consumer. It trades area for WIDTH cycles of latency.

---
 rtl/serial_adder_if.sv | 36 +++
 rtl/serial_adder.sv | 108 ++++++++++
 tb/tb_serial_adder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Handshake bundle for serial_adder: operand channel (in_*) and result channel (out_*).
// The sub line exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             busy;

    // Valid/ready on both channels: a transfer happens on a rising clk edge where
    // valid and ready are both high; once raised, valid holds its payload until then.
    modport slave (
        input  in_valid, a, b, out_ready,
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        output in_ready, out_valid, sum, carry, busy
    );

    modport master (
        output in_valid, a, b, out_ready,
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        input  in_ready, out_valid, sum, carry, busy
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock through a carry flop.
// Optional SERIAL_ADDER_SUB_EN adds a sub input that turns the operation into a - b.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_if.slave       bus,
    output logic [1:0]          state_dbg
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    logic [WIDTH-1:0] sumreg;
    logic [WIDTH-1:0] sum_q;
    logic             c;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             s;
    logic             c_next;
    logic [WIDTH:0]   sum_shift;
    logic             last_bit;
    logic             b_inv;
    logic             c_init;

`ifdef SERIAL_ADDER_SUB_EN
    assign b_inv  = bus.sub;
    assign c_init = bus.sub;
`else
    assign b_inv  = 1'b0;
    assign c_init = 1'b0;
`endif

    // Full-adder slice on the current LSBs; sum_shift keeps the insert legal at WIDTH=1.
    assign s         = areg[0] ^ breg[0] ^ c;
    assign c_next    = (areg[0] & breg[0]) | (areg[0] & c) | (breg[0] & c);
    assign sum_shift = {s, sumreg};
    assign last_bit  = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = bus.in_valid ? RUN : IDLE;
            RUN:     state_next = last_bit ? DONE : RUN;
            DONE:    state_next = bus.out_ready ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.busy      = (state == RUN);
        bus.sum       = sum_q;
        bus.carry     = carry_q;
        state_dbg     = state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            areg    <= '0;
            breg    <= '0;
            sumreg  <= '0;
            sum_q   <= '0;
            c       <= 1'b0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        areg <= bus.a;
                        breg <= b_inv ? ~bus.b : bus.b;
                        c    <= c_init;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    sumreg <= sum_shift[WIDTH:1];
                    areg   <= areg >> 1;
                    breg   <= breg >> 1;
                    c      <= c_next;
                    cnt    <= cnt + 1'b1;
                    // Result registers change only here, so they hold through DONE and IDLE.
                    if (last_bit) begin
                        sum_q   <= sum_shift[WIDTH:1];
                        carry_q <= c_next;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 main instance plus a WIDTH=1 instance.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] st8;
    logic [1:0] st1;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(1)) bus1 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave), .state_dbg(st8));
    serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave), .state_dbg(st1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation on the WIDTH=8 instance; optional backpressure and junk input pulses.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic sub, input logic [7:0] exp_sum, input logic exp_c,
                          input int hold, input logic junk);
        int lat = 0;
        int busy_cnt = 0;
        int w = 0;
        while (!bus8.in_ready && w < 50) begin tick(); w++; end
        check({tag, "_in_ready"}, 32'(bus8.in_ready), 32'd1);
        bus8.in_valid = 1'b1;
        bus8.a = av;
        bus8.b = bv;
`ifdef SERIAL_ADDER_SUB_EN
        bus8.sub = sub;
`endif
        tick();
        bus8.in_valid = 1'b0;
        while (!bus8.out_valid && lat < 100) begin
            if (bus8.busy) busy_cnt++;
            if (junk) begin
                bus8.in_valid = 1'($urandom_range(0, 1));
                bus8.a = 8'($urandom_range(0, 255));
                bus8.b = 8'($urandom_range(0, 255));
            end
            tick();
            lat++;
        end
        bus8.in_valid = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'd8);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
        check({tag, "_sum"}, 32'(bus8.sum), 32'(exp_sum));
        check({tag, "_carry"}, 32'(bus8.carry), 32'(exp_c));
        for (int i = 0; i < hold; i++) begin
            if (junk) begin
                bus8.in_valid = 1'b1;
                bus8.a = 8'h11;
                bus8.b = 8'h22;
            end
            tick();
            check({tag, "_hold_valid"}, 32'(bus8.out_valid), 32'd1);
            check({tag, "_hold_sum"}, 32'(bus8.sum), 32'(exp_sum));
            check({tag, "_hold_carry"}, 32'(bus8.carry), 32'(exp_c));
            check({tag, "_hold_in_ready"}, 32'(bus8.in_ready), 32'd0);
        end
        bus8.in_valid = 1'b0;
        bus8.out_ready = 1'b1;
        tick();
        bus8.out_ready = 1'b0;
        check({tag, "_post_in_ready"}, 32'(bus8.in_ready), 32'd1);
        check({tag, "_post_out_valid"}, 32'(bus8.out_valid), 32'd0);
        check({tag, "_post_sum"}, 32'(bus8.sum), 32'(exp_sum));
    endtask

    initial begin
        int lat;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.out_ready = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        bus8.sub = 1'b0;
        bus1.sub = 1'b0;
`endif
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(bus8.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
        check("rst_busy", 32'(bus8.busy), 32'd0);
        check("rst_sum", 32'(bus8.sum), 32'd0);
        check("rst_carry", 32'(bus8.carry), 32'd0);
        check("rst_state", 32'(st8), 32'd0);

        run_op("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0, 1'b0);
        run_op("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 1'b0);
        run_op("a5_5a", 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 0, 1'b0);
        run_op("bp_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 5, 1'b1);

        // Reset on the 4th RUN edge of 0x3C + 0x0F.
        bus8.in_valid = 1'b1; bus8.a = 8'h3C; bus8.b = 8'h0F;
        tick();
        bus8.in_valid = 1'b0;
        tick(); tick(); tick();
        check("mid_busy", 32'(bus8.busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_state", 32'(st8), 32'd0);
        check("mid_rst_in_ready", 32'(bus8.in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(bus8.out_valid), 32'd0);
        check("mid_rst_sum", 32'(bus8.sum), 32'd0);
        check("mid_rst_carry", 32'(bus8.carry), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("mid_rst_no_result", 32'(bus8.out_valid), 32'd0);
        end
        run_op("after_rst", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        run_op("sub_5_7", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 0, 1'b0);
        run_op("sub_7_5", 8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 0, 1'b0);
        run_op("sub0_add", 8'h07, 8'h05, 1'b0, 8'h0C, 1'b0, 0, 1'b0);
`endif

        // WIDTH=1 instance: 1 + 1 -> sum 0, carry 1 after a single RUN cycle.
        check("w1_in_ready", 32'(bus1.in_ready), 32'd1);
        bus1.in_valid = 1'b1; bus1.a = 1'b1; bus1.b = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        check("w1_busy", 32'(bus1.busy), 32'd1);
        lat = 0;
        while (!bus1.out_valid && lat < 20) begin tick(); lat++; end
        check("w1_latency", 32'(lat), 32'd1);
        check("w1_sum", 32'(bus1.sum), 32'd0);
        check("w1_carry", 32'(bus1.carry), 32'd1);
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
        check("w1_post_in_ready", 32'(bus1.in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
